my_mem_dut: RTL and testbench



---
 rtl/my_mem_dut.sv | 144 ++++++++++++++
 tb/tb_my_mem_dut.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/my_mem_dut.sv
// Small register-file memory with a pipelined read path, uninitialised-read flag
// and saturating access counters. Optional macro MY_MEM_WR_BYPASS_EN makes a
// simultaneous read+write write-first instead of read-first.
module my_mem_dut #(
  parameter int ADDR_W     = 2,
  parameter int DATA_W     = 8,
  parameter int RD_LATENCY = 1,  // legal range 1..4
  parameter int CNT_W      = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid,
  input  logic [ADDR_W-1:0] addr,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              rdata_valid,
  output logic              rd_err,
  output logic [CNT_W-1:0]  wr_cnt,
  output logic [CNT_W-1:0]  rd_cnt
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int LAST  = RD_LATENCY - 1;

  // Handshake: a command is accepted at any rising edge where valid is high;
  // there is no ready/backpressure, so wr_en/rd_en are don't-care when valid is low.
  logic wr_acc;
  logic rd_acc;
  assign wr_acc = valid & wr_en;
  assign rd_acc = valid & rd_en;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [DEPTH-1:0]  written_q, written_d;

  logic [RD_LATENCY-1:0] pipe_vld_q, pipe_vld_d;
  logic [RD_LATENCY-1:0] pipe_err_q, pipe_err_d;
  logic [DATA_W-1:0]     pipe_data_q [RD_LATENCY];
  logic [DATA_W-1:0]     pipe_data_d [RD_LATENCY];

  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              rdata_valid_q, rdata_valid_d;
  logic              rd_err_q, rd_err_d;
  logic [CNT_W-1:0]  wr_cnt_q, wr_cnt_d;
  logic [CNT_W-1:0]  rd_cnt_q, rd_cnt_d;

  logic [DATA_W-1:0] s1_data;
  logic              s1_err;

  always_comb begin
    mem_d     = mem_q;
    written_d = written_q;
    if (wr_acc) begin
      mem_d[addr]     = wdata;
      written_d[addr] = 1'b1;
    end
  end

  // Stage-1 capture sees the pre-write array contents unless bypass is built in.
  always_comb begin
    s1_data = mem_q[addr];
    s1_err  = ~written_q[addr];
`ifdef MY_MEM_WR_BYPASS_EN
    if (wr_acc) begin
      s1_data = wdata;
      s1_err  = 1'b0;
    end
`endif
  end

  always_comb begin
    pipe_vld_d  = pipe_vld_q;
    pipe_err_d  = pipe_err_q;
    pipe_data_d = pipe_data_q;
    pipe_vld_d[0]  = rd_acc;
    pipe_err_d[0]  = s1_err;
    pipe_data_d[0] = s1_data;
    for (int i = 1; i < RD_LATENCY; i++) begin
      pipe_vld_d[i]  = pipe_vld_q[i-1];
      pipe_err_d[i]  = pipe_err_q[i-1];
      pipe_data_d[i] = pipe_data_q[i-1];
    end
  end

  always_comb begin
    rdata_d       = rdata_q;
    rdata_valid_d = pipe_vld_q[LAST];
    rd_err_d      = pipe_vld_q[LAST] & pipe_err_q[LAST];
    if (pipe_vld_q[LAST]) begin
      rdata_d = pipe_data_q[LAST];
    end
  end

  // Counters stick at all-ones rather than wrapping.
  always_comb begin
    wr_cnt_d = wr_cnt_q;
    rd_cnt_d = rd_cnt_q;
    if (wr_acc && (wr_cnt_q != '1)) begin
      wr_cnt_d = wr_cnt_q + CNT_W'(1);
    end
    if (rd_acc && (rd_cnt_q != '1)) begin
      rd_cnt_d = rd_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      written_q  <= '0;
      pipe_vld_q <= '0;
      pipe_err_q <= '0;
      for (int i = 0; i < RD_LATENCY; i++) begin
        pipe_data_q[i] <= '0;
      end
      rdata_q       <= '0;
      rdata_valid_q <= 1'b0;
      rd_err_q      <= 1'b0;
      wr_cnt_q      <= '0;
      rd_cnt_q      <= '0;
    end else begin
      mem_q         <= mem_d;
      written_q     <= written_d;
      pipe_vld_q    <= pipe_vld_d;
      pipe_err_q    <= pipe_err_d;
      pipe_data_q   <= pipe_data_d;
      rdata_q       <= rdata_d;
      rdata_valid_q <= rdata_valid_d;
      rd_err_q      <= rd_err_d;
      wr_cnt_q      <= wr_cnt_d;
      rd_cnt_q      <= rd_cnt_d;
    end
  end

  assign rdata       = rdata_q;
  assign rdata_valid = rdata_valid_q;
  assign rd_err      = rd_err_q;
  assign wr_cnt      = wr_cnt_q;
  assign rd_cnt      = rd_cnt_q;

endmodule

// File: tb/tb_my_mem_dut.sv
// Directed bench for my_mem_dut: a per-cycle vector table plus hand-written
// sequences for asynchronous reset mid-read and counter saturation.
module tb_my_mem_dut;

  logic       clk;
  logic       reset;
  logic       valid;
  logic [1:0] addr;
  logic       wr_en;
  logic       rd_en;
  logic [7:0] wdata;
  logic [7:0] rdata;
  logic       rdata_valid;
  logic       rd_err;
  logic [7:0] wr_cnt;
  logic [7:0] rd_cnt;

  int pass_cnt  = 0;
  int total_cnt = 0;

  my_mem_dut dut (
    .clk        (clk),
    .reset      (reset),
    .valid      (valid),
    .addr       (addr),
    .wr_en      (wr_en),
    .rd_en      (rd_en),
    .wdata      (wdata),
    .rdata      (rdata),
    .rdata_valid(rdata_valid),
    .rd_err     (rd_err),
    .wr_cnt     (wr_cnt),
    .rd_cnt     (rd_cnt)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic       w;
    logic       r;
    logic [1:0] a;
    logic [7:0] wd;
    logic       e_vld;
    logic [7:0] e_rdata;
    logic       e_err;
    logic [7:0] e_wcnt;
    logic [7:0] e_rcnt;
  } vec_t;

  localparam int NVEC = 23;
  vec_t vecs[NVEC];

  function automatic vec_t mk(logic v, logic w, logic r, logic [1:0] a, logic [7:0] wd,
                              logic ev, logic [7:0] erd, logic ee, logic [7:0] ewc,
                              logic [7:0] erc);
    vec_t t;
    t.v = v; t.w = w; t.r = r; t.a = a; t.wd = wd;
    t.e_vld = ev; t.e_rdata = erd; t.e_err = ee; t.e_wcnt = ewc; t.e_rcnt = erc;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end else begin
      pass_cnt++;
    end
  endtask

  // driver tasks
  task automatic drive(input logic v, input logic w, input logic r, input logic [1:0] a,
                       input logic [7:0] wd);
    valid = v; wr_en = w; rd_en = r; addr = a; wdata = wd;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_outs(input string tag, input logic ev, input logic [7:0] erd,
                          input logic ee, input logic [7:0] ewc, input logic [7:0] erc);
    chk({tag, ".rdata_valid"}, 32'(rdata_valid), 32'(ev));
    chk({tag, ".rdata"},       32'(rdata),       32'(erd));
    chk({tag, ".rd_err"},      32'(rd_err),      32'(ee));
    chk({tag, ".wr_cnt"},      32'(wr_cnt),      32'(ewc));
    chk({tag, ".rd_cnt"},      32'(rd_cnt),      32'(erc));
  endtask

  initial begin
    logic [7:0] coll;
`ifdef MY_MEM_WR_BYPASS_EN
    coll = 8'h5A;
`else
    coll = 8'h11;
`endif
    // Expected outputs are those seen after the edge that samples the row's inputs.
    vecs[0]  = mk(1, 0, 1, 2, 8'h00,  0, 8'h00, 0, 0, 1);
    vecs[1]  = mk(0, 0, 0, 0, 8'h00,  1, 8'h00, 1, 0, 1);
    vecs[2]  = mk(1, 1, 0, 1, 8'hA5,  0, 8'h00, 0, 1, 1);
    vecs[3]  = mk(1, 0, 1, 1, 8'h00,  0, 8'h00, 0, 1, 2);
    vecs[4]  = mk(0, 0, 0, 0, 8'h00,  1, 8'hA5, 0, 1, 2);
    vecs[5]  = mk(0, 0, 0, 0, 8'h00,  0, 8'hA5, 0, 1, 2);
    vecs[6]  = mk(1, 1, 0, 0, 8'h11,  0, 8'hA5, 0, 2, 2);
    vecs[7]  = mk(1, 1, 0, 1, 8'h22,  0, 8'hA5, 0, 3, 2);
    vecs[8]  = mk(1, 1, 0, 2, 8'h33,  0, 8'hA5, 0, 4, 2);
    vecs[9]  = mk(1, 1, 0, 3, 8'h44,  0, 8'hA5, 0, 5, 2);
    vecs[10] = mk(1, 0, 1, 3, 8'h00,  0, 8'hA5, 0, 5, 3);
    vecs[11] = mk(1, 0, 1, 2, 8'h00,  1, 8'h44, 0, 5, 4);
    vecs[12] = mk(1, 0, 1, 1, 8'h00,  1, 8'h33, 0, 5, 5);
    vecs[13] = mk(1, 0, 1, 0, 8'h00,  1, 8'h22, 0, 5, 6);
    vecs[14] = mk(0, 0, 0, 0, 8'h00,  1, 8'h11, 0, 5, 6);
    vecs[15] = mk(0, 0, 0, 0, 8'h00,  0, 8'h11, 0, 5, 6);
    vecs[16] = mk(1, 1, 1, 0, 8'h5A,  0, 8'h11, 0, 6, 7);
    vecs[17] = mk(0, 0, 0, 0, 8'h00,  1, coll,  0, 6, 7);
    vecs[18] = mk(1, 0, 1, 0, 8'h00,  0, coll,  0, 6, 8);
    vecs[19] = mk(0, 0, 0, 0, 8'h00,  1, 8'h5A, 0, 6, 8);
    vecs[20] = mk(0, 1, 1, 3, 8'hFF,  0, 8'h5A, 0, 6, 8);
    vecs[21] = mk(1, 0, 1, 3, 8'h00,  0, 8'h5A, 0, 6, 9);
    vecs[22] = mk(0, 0, 0, 0, 8'h00,  1, 8'h44, 0, 6, 9);

    drive(0, 0, 0, 0, 8'h00);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk_outs("reset", 0, 8'h00, 0, 0, 0);
    reset = 1'b0;

    for (int i = 0; i < NVEC; i++) begin
      drive(vecs[i].v, vecs[i].w, vecs[i].r, vecs[i].a, vecs[i].wd);
      step();
      chk_outs($sformatf("vec%0d", i), vecs[i].e_vld, vecs[i].e_rdata, vecs[i].e_err,
               vecs[i].e_wcnt, vecs[i].e_rcnt);
    end

    // Asynchronous reset lands between the accept edge and the result edge.
    drive(1, 0, 1, 1, 8'h00);
    @(posedge clk);
    #2;
    drive(0, 0, 0, 0, 8'h00);
    reset = 1'b1;
    #1;
    chk_outs("async_rst", 0, 8'h00, 0, 0, 0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("post_rst%0d.rdata_valid", i), 32'(rdata_valid), 32'd0);
    end

    // Memory was cleared, so addr 1 now reads as unwritten.
    drive(1, 0, 1, 1, 8'h00);
    step();
    drive(0, 0, 0, 0, 8'h00);
    step();
    chk_outs("rd_after_rst", 1, 8'h00, 1, 0, 1);

    // 300 writes: wr_cnt must stop at 255; last write is addr 3 data 0x2B.
    for (int i = 0; i < 300; i++) begin
      drive(1, 1, 0, 2'(i), 8'(i));
      step();
    end
    drive(0, 0, 0, 0, 8'h00);
    step();
    chk("sat.wr_cnt", 32'(wr_cnt), 32'd255);
    chk("sat.rd_cnt", 32'(rd_cnt), 32'd1);

    drive(1, 0, 1, 3, 8'h00);
    step();
    drive(0, 0, 0, 0, 8'h00);
    step();
    chk_outs("rd_after_sat", 1, 8'h2B, 0, 255, 2);

    // final report
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
